// File: rtl/radix4_booth_mult_pkg.sv
// Shared widths, iteration count and FSM encoding for the radix-4 Booth multiplier.
package radix4_booth_mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int ITER_COUNT = 16;
    localparam int CNT_WIDTH  = 4;
    // Two guard bits keep A +/- 2M from ever overflowing the accumulator.
    localparam int ACC_WIDTH  = MULT_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: {q[i+1], q[i], q[i-1]} -> digit select in {0, +-M, +-2M}.
module booth_recoder (
    input  logic [2:0] bits,
    output logic       zero,
    output logic       two,
    output logic       neg
);

    always_comb begin
        zero = (bits == 3'b000) || (bits == 3'b111);
        two  = (bits == 3'b011) || (bits == 3'b100);
        neg  = bits[2] && !(bits[1] && bits[0]);
    end

endmodule

// File: rtl/rca_adder.sv
// Parameterized ripple-carry adder with carry-in; carry-out is not needed by its users.
module rca_adder #(
    parameter int W = 34
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

endmodule

// File: rtl/radix4_booth_mult.sv
// Sequential signed 32x32 radix-4 Booth multiplier: 16 iterations, low 32-bit product
// plus a flag for results that do not fit in signed 32 bits.
module radix4_booth_mult
    import radix4_booth_mult_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MULT_WIDTH-1:0] multiplicand,
    input  logic [MULT_WIDTH-1:0] multiplier,
    output logic [MULT_WIDTH-1:0] product,
    output logic                  overflow,
    output logic                  data_result_ready,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [MULT_WIDTH-1:0] m_q, m_d;
    logic [ACC_WIDTH-1:0]  a_q, a_d;
    logic [MULT_WIDTH:0]   q_q, q_d;       // {Q, q_-1}
    logic [MULT_WIDTH-1:0] product_q, product_d;
    logic                  overflow_q, overflow_d;

    logic                  sel_zero, sel_two, sel_neg;
    logic [ACC_WIDTH-1:0]  m_ext, m_sel, addend, sum;
    logic [ACC_WIDTH-1:0]  iter_a;
    logic [MULT_WIDTH:0]   iter_q;
    logic [MULT_WIDTH:0]   full_hi;        // full[63:31] after the final iteration

    booth_recoder u_recoder (
        .bits (q_q[2:0]),
        .zero (sel_zero),
        .two  (sel_two),
        .neg  (sel_neg)
    );

    always_comb begin
        m_ext  = {{(ACC_WIDTH-MULT_WIDTH){m_q[MULT_WIDTH-1]}}, m_q};
        m_sel  = sel_zero ? '0 : (sel_two ? {m_ext[ACC_WIDTH-2:0], 1'b0} : m_ext);
        addend = sel_neg ? ~m_sel : m_sel;
    end

    rca_adder #(.W(ACC_WIDTH)) u_adder (
        .a   (a_q),
        .b   (addend),
        .cin (sel_neg),
        .sum (sum)
    );

    always_comb begin
        iter_a  = {{2{sum[ACC_WIDTH-1]}}, sum[ACC_WIDTH-1:2]};
        iter_q  = {sum[1:0], q_q[MULT_WIDTH:2]};
        full_hi = {iter_a[MULT_WIDTH-1:0], iter_q[MULT_WIDTH]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_d        = m_q;
        a_d        = a_q;
        q_d        = q_q;
        product_d  = product_q;
        overflow_d = overflow_q;

        if (state_q == RUN) begin
            a_d   = iter_a;
            q_d   = iter_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_WIDTH'(ITER_COUNT - 1)) begin
                state_d    = DONE;
                product_d  = iter_q[MULT_WIDTH:1];
                overflow_d = !((&full_hi) || !(|full_hi));
            end
        end else if (start) begin
            // Accept from IDLE or DONE; DONE acceptance gives back-to-back operation.
            state_d = RUN;
            cnt_d   = '0;
            m_d     = multiplicand;
            a_d     = '0;
            q_d     = {multiplier, 1'b0};
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            m_q        <= '0;
            a_q        <= '0;
            q_q        <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            a_q        <= a_d;
            q_q        <= q_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign product           = product_q;
    assign overflow          = overflow_q;
    assign busy              = (state_q == RUN);
    assign data_result_ready = (state_q == DONE);

endmodule

// File: tb/tb_radix4_booth_mult.sv
// Scoreboard bench for radix4_booth_mult: directed corners, continuous start, mid-op reset,
// and 1000 random signed operand pairs against a 64-bit arithmetic model.
module tb_radix4_booth_mult;

    localparam longint S32_MAX = 64'sd2147483647;
    localparam longint S32_MIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand, multiplier;
    logic [31:0] product;
    logic        overflow, data_result_ready, busy;

    typedef struct {
        logic [31:0] p;
        logic        o;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   brun = 0;
    logic prev_ready = 1'b0;
    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    radix4_booth_mult dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .multiplicand      (multiplicand),
        .multiplier        (multiplier),
        .product           (product),
        .overflow          (overflow),
        .data_result_ready (data_result_ready),
        .busy              (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] m, input logic [31:0] q, input int acc);
        exp_t   r;
        longint p;
        p     = longint'($signed(m)) * longint'($signed(q));
        r.p   = p[31:0];
        r.o   = (p > S32_MAX) || (p < S32_MIN);
        r.acc = acc;
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 4)
            0: return $urandom;
            1: return 32'($signed(16'($urandom)));
            2: return corners[$urandom % 5];
            default: return $urandom & 32'h0000FFFF;
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever a result is presented.
    always @(negedge clk) begin
        if (reset) begin
            prev_ready = 1'b0;
        end else begin
            if (data_result_ready) begin
                chk("ready_pulse_width", 32'(prev_ready), 32'd0);
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("product", product, e.p);
                    chk("overflow", 32'(overflow), 32'(e.o));
                    chk("latency", 32'(cyc - e.acc), 32'd16);
                end
            end
            prev_ready = data_result_ready;
        end
    end

    // Every busy window must be exactly 16 cycles long.
    always @(negedge clk) begin
        if (reset) brun = 0;
        else if (busy) brun++;
        else if (brun != 0) begin
            chk("busy_cycles", 32'(brun), 32'd16);
            brun = 0;
        end
    end

    // Called at a negedge; returns at the negedge of the DONE cycle with start low.
    task automatic issue(input logic [31:0] m, input logic [31:0] q,
                         input logic [31:0] ep, input logic eo);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got busy stuck high expected idle");
            return;
        end
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        sb.push_back('{ep, eo, cyc + 1});
        @(negedge clk);
        // Junk start and operands while running must be ignored.
        for (int i = 0; i < 15; i++) begin
            start = 1'($urandom % 2);
            multiplicand = $urandom;
            multiplier = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        multiplicand = $urandom;
        multiplier = $urandom;
        @(negedge clk);
    endtask

    task automatic issue_rand(input logic [31:0] m, input logic [31:0] q);
        exp_t r;
        r = model(m, q, 0);
        issue(m, q, r.p, r.o);
    endtask

    initial begin
        logic [31:0] rm, rq;
        int w;
        reset = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (2) @(negedge clk);
        chk("rst_product", product, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ready", 32'(data_result_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(32'd7, 32'd6, 32'h0000002A, 1'b0);
        issue(-32'sd3, 32'd5, 32'hFFFFFFF1, 1'b0);
        issue(32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        issue(32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
        issue(32'd0, 32'd12345, 32'h00000000, 1'b0);
        issue(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0);
        issue(32'h80000000, 32'd1, 32'h80000000, 1'b0);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        repeat (3) @(negedge clk);

        // start held high, operands changing every cycle
        for (int i = 0; i < 60; i++) begin
            start = 1'b1;
            rm = $urandom;
            rq = $urandom;
            multiplicand = rm;
            multiplier = rq;
            if (busy === 1'b0) sb.push_back(model(rm, rq, cyc + 1));
            @(negedge clk);
        end
        start = 1'b0;

        // Reset during the 8th RUN cycle abandons the operation.
        issue(32'd7, 32'd6, 32'h0000002A, 1'b0);
        start = 1'b1;
        multiplicand = 32'd123;
        multiplier = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_product", product, 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        chk("midrst_ready", 32'(data_result_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        issue(32'd2, 32'd3, 32'd6, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            issue_rand(pick(), pick());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
